dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester round-robin arbiter sharing the single-port data memory (32 x 32-bit, 5-bit word address).
- The memory writes on the clock edge when its store enable is high and reads combinationally.
- Port 0 connects to the core load/store unit; port 1 to a debug/DMA master.
- The arbiter issues at most one access per cycle and returns read data one cycle after acceptance, with a valid pulse.

Parameters:
N, 32, data width in bits
ADDR, 5, word address width; memory depth is 2**ADDR

Ports:
clk_i  input  1  system clock, rising edge
rst_ni  input  1  asynchronous active-low reset
req0_valid_i  input  1  port 0 request valid
req0_we_i  input  1  port 0 write (1) / read (0)
req0_addr_i  input  ADDR  port 0 word address
req0_wdata_i  input  N  port 0 store data
req0_ready_o  output  1  port 0 request accepted this cycle
req0_rvalid_o  output  1  port 0 read data valid (1-cycle pulse)
req0_rdata_o  output  N  port 0 read data
req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i  input  1/1/ADDR/N  port 1 request, same meaning as port 0
req1_ready_o, req1_rvalid_o, req1_rdata_o  output  1/1/N  port 1 response, same meaning as port 0
mem_addr_o  output  ADDR  memory address
mem_st_data_o  output  N  memory store data
mem_st_en_o  output  1  memory store enable
mem_ld_data_i  input  N  memory combinational load data

Behaviour:
- Clock clk_i, reset rst_ni: asynchronous, active-low; all state clears immediately on assertion.
- State: last_grant (1 bit); rvalid0/rvalid1 (1 bit each); rdata0/rdata1 (N bits each).
- Reset values: last_grant=1 (port 0 wins the first tie); rvalid*=0; rdata*=0.
- Grant (combinational, same cycle):
  - Only one port valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - None valid: no grant.
- reqX_ready_o = grant to X. Combinational; depends only on valid inputs and last_grant, never on ready or rvalid.
- Memory drive:
  - Granted: mem_addr_o = granted addr; mem_st_data_o = granted wdata; mem_st_en_o = granted we.
  - Idle: mem_addr_o=0, mem_st_data_o=0, mem_st_en_o=0.
- Handshake: a transaction is accepted on a rising edge where valid & ready. A requester not granted must keep valid, we, addr and wdata stable until accepted. The arbiter does not check stability.
- last_grant updates to the granted port on every accepted edge; it holds when idle.
- Read response:
  - On accepting a read from port X, capture mem_ld_data_i into rdataX and set rvalidX=1 for exactly the next cycle.
  - Latency: request accepted in cycle T, data valid in cycle T+1.
  - rdataX holds its last value after rvalid drops.
- Write: the memory updates at the accept edge; rvalid is not raised for writes.
- Back-to-back: a port may be accepted in consecutive cycles. rvalid then stays high across consecutive accepted reads, with new data each cycle.
- Read-after-write: a write accepted at T followed by a read of the same address accepted at T+1 (either port) returns the new data at T+2.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1. No starvation beyond 1 cycle.
- Address width: addresses pass through unmodified; no bounds checking. All 2**ADDR words are reachable.
- Reset mid-operation: rvalid drops immediately and any pending response is lost. After release, arbitration restarts with port 0 priority.
- Invariants:
  - mem_st_en_o never high without a grant.
  - req0_ready_o & req1_ready_o is never 1.

Test Plan:
1. Reset, then port 0 writes addr 5 = 0xDEADBEEF; next cycle port 0 reads addr 5 -> req0_ready_o=1 both cycles; req0_rvalid_o=1 one cycle later with req0_rdata_o=0xDEADBEEF; mem_st_en_o high only in the write cycle.
2. Both ports read (addr 1 and addr 2, preloaded 0x11/0x22) in the first cycle after reset -> port 0 granted first, port 1 the next cycle; rdata0=0x11 at T+1, rdata1=0x22 at T+2.
3. Both ports continuously valid for 6 cycles -> grant sequence 0,1,0,1,0,1; ready never high on both ports at once.
4. Port 1 writes addr 31 = 0xA5A5A5A5 while port 0 is idle, then port 0 reads addr 31 -> req0_rdata_o=0xA5A5A5A5; addr 31 (upper boundary) stored correctly; rvalid1 never asserted.
5. Idle cycles (no valid) -> mem_st_en_o=0, mem_addr_o=0, both ready=0; last_grant unchanged (next tie still goes to the port opposite the last winner).
6. Assert rst_ni low in the cycle after a read is accepted -> rvalid0 drops to 0 immediately; after release, a tie grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving a core LSU (port 0) and a debug/DMA master (port 1) shared access to a single-port data memory.
// Latency: grant and memory drive are combinational; read data returns with a one-cycle rvalid pulse the cycle after acceptance.
// Backpressure: a port that loses arbitration sees ready low and must hold its request stable until it is granted.
module dmem_arbiter #(
  parameter int N    = 32,
  parameter int ADDR = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req0_valid_i,
  input  logic            req0_we_i,
  input  logic [ADDR-1:0] req0_addr_i,
  input  logic [N-1:0]    req0_wdata_i,
  output logic            req0_ready_o,
  output logic            req0_rvalid_o,
  output logic [N-1:0]    req0_rdata_o,
  input  logic            req1_valid_i,
  input  logic            req1_we_i,
  input  logic [ADDR-1:0] req1_addr_i,
  input  logic [N-1:0]    req1_wdata_i,
  output logic            req1_ready_o,
  output logic            req1_rvalid_o,
  output logic [N-1:0]    req1_rdata_o,
  output logic [ADDR-1:0] mem_addr_o,
  output logic [N-1:0]    mem_st_data_o,
  output logic            mem_st_en_o,
  input  logic [N-1:0]    mem_ld_data_i
);

  // last_grant = 1 means port 1 won most recently, so port 0 wins the next tie
  logic         last_grant;
  logic         grant0;
  logic         grant1;
  logic         rvalid0;
  logic         rvalid1;
  logic [N-1:0] rdata0;
  logic [N-1:0] rdata1;

  // Grant: a lone requester always wins; on a tie the port that did not win last time wins
  always_comb begin
    grant0 = req0_valid_i & (~req1_valid_i | last_grant);
    grant1 = req1_valid_i & (~req0_valid_i | ~last_grant);
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Memory drive: pass the winner's request through, park everything at zero when idle
  always_comb begin
    mem_addr_o    = '0;
    mem_st_data_o = '0;
    mem_st_en_o   = 1'b0;
    if (grant0) begin
      mem_addr_o    = req0_addr_i;
      mem_st_data_o = req0_wdata_i;
      mem_st_en_o   = req0_we_i;
    end else if (grant1) begin
      mem_addr_o    = req1_addr_i;
      mem_st_data_o = req1_wdata_i;
      mem_st_en_o   = req1_we_i;
    end
  end

  // Round-robin pointer: remember the winner of each accepted transfer, hold when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Read response: capture combinational load data at the accept edge, pulse rvalid for one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= grant0 & ~req0_we_i;
      rvalid1 <= grant1 & ~req1_we_i;
      if (grant0 && !req0_we_i) begin
        rdata0 <= mem_ld_data_i;
      end
      if (grant1 && !req1_we_i) begin
        rdata1 <= mem_ld_data_i;
      end
    end
  end

  assign req0_rvalid_o = rvalid0;
  assign req1_rvalid_o = rvalid1;
  assign req0_rdata_o  = rdata0;
  assign req1_rdata_o  = rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of per-cycle vectors plus a hand-written reset-mid-read sequence.
// A behavioural 32x32 memory sits on the memory port; expected values are hand-computed in the table.
// Inputs are driven on the falling edge and outputs sampled 1ns later, well away from the rising edge.
module tb_dmem_arbiter;
  localparam int N    = 32;
  localparam int ADDR = 5;

  logic            clk;
  logic            rst_n;
  logic            v0, we0, v1, we1;
  logic [ADDR-1:0] a0, a1;
  logic [N-1:0]    d0, d1;
  logic            rdy0, rdy1, rv0, rv1;
  logic [N-1:0]    rd0, rd1;
  logic [ADDR-1:0] mem_addr;
  logic [N-1:0]    mem_st_data;
  logic            mem_st_en;
  logic [N-1:0]    mem_ld_data;
  logic [N-1:0]    mem [2**ADDR];

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic            v0, we0;
    logic [ADDR-1:0] a0;
    logic [N-1:0]    d0;
    logic            v1, we1;
    logic [ADDR-1:0] a1;
    logic [N-1:0]    d1;
    logic            e_rdy0, e_rdy1, e_rv0, e_rv1;
    logic [N-1:0]    e_rd0, e_rd1;
    logic            e_st;
    logic [ADDR-1:0] e_addr;
    logic [N-1:0]    e_sd;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  dmem_arbiter #(.N(N), .ADDR(ADDR)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req0_valid_i  (v0),
    .req0_we_i     (we0),
    .req0_addr_i   (a0),
    .req0_wdata_i  (d0),
    .req0_ready_o  (rdy0),
    .req0_rvalid_o (rv0),
    .req0_rdata_o  (rd0),
    .req1_valid_i  (v1),
    .req1_we_i     (we1),
    .req1_addr_i   (a1),
    .req1_wdata_i  (d1),
    .req1_ready_o  (rdy1),
    .req1_rvalid_o (rv1),
    .req1_rdata_o  (rd1),
    .mem_addr_o    (mem_addr),
    .mem_st_data_o (mem_st_data),
    .mem_st_en_o   (mem_st_en),
    .mem_ld_data_i (mem_ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write on the rising edge
  assign mem_ld_data = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_st_en) mem[mem_addr] <= mem_st_data;
  end

  function automatic vec_t mk(
    input logic v0_, we0_, input logic [ADDR-1:0] a0_, input logic [N-1:0] d0_,
    input logic v1_, we1_, input logic [ADDR-1:0] a1_, input logic [N-1:0] d1_,
    input logic r0_, r1_, rv0_, rv1_, input logic [N-1:0] rd0_, rd1_,
    input logic st_, input logic [ADDR-1:0] ad_, input logic [N-1:0] sd_);
    vec_t t;
    t.v0 = v0_; t.we0 = we0_; t.a0 = a0_; t.d0 = d0_;
    t.v1 = v1_; t.we1 = we1_; t.a1 = a1_; t.d1 = d1_;
    t.e_rdy0 = r0_; t.e_rdy1 = r1_; t.e_rv0 = rv0_; t.e_rv1 = rv1_;
    t.e_rd0 = rd0_; t.e_rd1 = rd1_; t.e_st = st_; t.e_addr = ad_; t.e_sd = sd_;
    return t;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0_, we0_, input logic [ADDR-1:0] a0_, input logic [N-1:0] d0_,
                       input logic v1_, we1_, input logic [ADDR-1:0] a1_, input logic [N-1:0] d1_);
    v0 = v0_; we0 = we0_; a0 = a0_; d0 = d0_;
    v1 = v1_; we1 = we1_; a1 = a1_; d1 = d1_;
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR; i++) mem[i] = '0;
    mem[1] = 32'h11;
    mem[2] = 32'h22;

    // Rows: inputs for the cycle, then ready/rvalid/rdata/memory-drive seen in that same cycle
    vecs[0]  = mk(1,0,1,0,            1,0,2,0,            1,0,0,0,0,0,             0,1,0);
    vecs[1]  = mk(0,0,0,0,            1,0,2,0,            0,1,1,0,32'h11,0,        0,2,0);
    vecs[2]  = mk(0,0,0,0,            0,0,0,0,            0,0,0,1,0,32'h22,        0,0,0);
    vecs[3]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0,            1,0,0,0,0,0,             1,5,32'hDEADBEEF);
    vecs[4]  = mk(1,0,5,0,            0,0,0,0,            1,0,0,0,0,0,             0,5,0);
    vecs[5]  = mk(0,0,0,0,            0,0,0,0,            0,0,1,0,32'hDEADBEEF,0,  0,0,0);
    vecs[6]  = mk(0,0,0,0,            1,1,10,32'h10101010, 0,1,0,0,0,0,            1,10,32'h10101010);
    vecs[7]  = mk(1,0,1,0,            1,0,2,0,            1,0,0,0,0,0,             0,1,0);
    vecs[8]  = mk(1,0,1,0,            1,0,2,0,            0,1,1,0,32'h11,0,        0,2,0);
    vecs[9]  = mk(1,0,1,0,            1,0,2,0,            1,0,0,1,0,32'h22,        0,1,0);
    vecs[10] = mk(1,0,1,0,            1,0,2,0,            0,1,1,0,32'h11,0,        0,2,0);
    vecs[11] = mk(1,0,1,0,            1,0,2,0,            1,0,0,1,0,32'h22,        0,1,0);
    vecs[12] = mk(1,0,1,0,            1,0,2,0,            0,1,1,0,32'h11,0,        0,2,0);
    vecs[13] = mk(0,0,0,0,            0,0,0,0,            0,0,0,1,0,32'h22,        0,0,0);
    vecs[14] = mk(0,0,0,0,            1,1,31,32'hA5A5A5A5, 0,1,0,0,0,0,            1,31,32'hA5A5A5A5);
    vecs[15] = mk(1,0,31,0,           0,0,0,0,            1,0,0,0,0,0,             0,31,0);
    vecs[16] = mk(0,0,0,0,            0,0,0,0,            0,0,1,0,32'hA5A5A5A5,0,  0,0,0);
    vecs[17] = mk(0,0,0,0,            0,0,0,0,            0,0,0,0,0,0,             0,0,0);
    vecs[18] = mk(1,0,1,0,            1,0,2,0,            0,1,0,0,0,0,             0,2,0);
    vecs[19] = mk(0,0,0,0,            0,0,0,0,            0,0,0,1,0,32'h22,        0,0,0);
    vecs[20] = mk(1,0,5,0,            0,0,0,0,            1,0,0,0,0,0,             0,5,0);
    vecs[21] = mk(1,0,31,0,           0,0,0,0,            1,0,1,0,32'hDEADBEEF,0,  0,31,0);
    vecs[22] = mk(0,0,0,0,            0,0,0,0,            0,0,1,0,32'hA5A5A5A5,0,  0,0,0);
    vecs[23] = mk(1,1,7,32'h77,       0,0,0,0,            1,0,0,0,0,0,             1,7,32'h77);
    vecs[24] = mk(0,0,0,0,            1,0,7,0,            0,1,0,0,0,0,             0,7,0);
    vecs[25] = mk(0,0,0,0,            0,0,0,0,            0,0,0,1,0,32'h77,        0,0,0);

    // Reset and check idle outputs
    rst_n = 1'b0;
    drive(0,0,0,0, 0,0,0,0);
    repeat (2) @(negedge clk);
    #1;
    check("reset rdy0",   {31'b0, rdy0}, 0);
    check("reset rdy1",   {31'b0, rdy1}, 0);
    check("reset rv0",    {31'b0, rv0},  0);
    check("reset rv1",    {31'b0, rv1},  0);
    check("reset rd0",    rd0, 0);
    check("reset rd1",    rd1, 0);
    check("reset st_en",  {31'b0, mem_st_en}, 0);
    check("reset addr",   {27'b0, mem_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("row%0d rdy0", i),  {31'b0, rdy0}, {31'b0, vecs[i].e_rdy0});
      check($sformatf("row%0d rdy1", i),  {31'b0, rdy1}, {31'b0, vecs[i].e_rdy1});
      check($sformatf("row%0d rv0", i),   {31'b0, rv0},  {31'b0, vecs[i].e_rv0});
      check($sformatf("row%0d rv1", i),   {31'b0, rv1},  {31'b0, vecs[i].e_rv1});
      check($sformatf("row%0d st_en", i), {31'b0, mem_st_en}, {31'b0, vecs[i].e_st});
      check($sformatf("row%0d addr", i),  {27'b0, mem_addr}, {27'b0, vecs[i].e_addr});
      check($sformatf("row%0d st_data", i), mem_st_data, vecs[i].e_sd);
      if (vecs[i].e_rv0) check($sformatf("row%0d rd0", i), rd0, vecs[i].e_rd0);
      if (vecs[i].e_rv1) check($sformatf("row%0d rd1", i), rd1, vecs[i].e_rd1);
    end

    // Reset arriving the cycle after a read is accepted kills the response and restores port 0 priority
    @(negedge clk);
    drive(1,0,1,0, 0,0,0,0);
    @(posedge clk);
    #1;
    drive(0,0,0,0, 0,0,0,0);
    check("midrst rv0 before", {31'b0, rv0}, 1);
    check("midrst rd0 before", rd0, 32'h11);
    rst_n = 1'b0;
    #1;
    check("midrst rv0 async", {31'b0, rv0}, 0);
    check("midrst rd0 async", rd0, 0);
    drive(1,0,1,0, 1,0,2,0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset tie rdy0", {31'b0, rdy0}, 1);
    check("post-reset tie rdy1", {31'b0, rdy1}, 0);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    #1;
    check("post-reset rv0", {31'b0, rv0}, 1);
    check("post-reset rd0", rd0, 32'h11);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
